pipeline_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (PC, IF, ID, EX, MEM, WB registers, incl. ID_EX).

---
 rtl/pipeline_ctrl_pkg.sv | 38 +++
 rtl/pipeline_ctrl_stall_watchdog.sv | 56 +++++
 rtl/pipeline_ctrl.sv | 100 ++++++++++
 tb/tb_pipeline_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: exception codes, stall vectors, FSM states.
package pipeline_ctrl_pkg;

   localparam int EXC_CODE_WIDTH = 5;
   typedef logic [EXC_CODE_WIDTH-1:0] exc_code_t;

   localparam exc_code_t EC_NONE = 5'h1f;
   localparam exc_code_t EC_ERET = 5'h1e;
   localparam exc_code_t EC_OV   = 5'h0c;

   localparam int STALL_W = 6;
   typedef logic [STALL_W-1:0] stall_t;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // bit0=PC .. bit5=WB; the first 0 above a run of 1s is the stage that takes a bubble
   localparam stall_t STALL_MEM  = 6'b011111;
   localparam stall_t STALL_EX   = 6'b001111;
   localparam stall_t STALL_ID   = 6'b000111;
   localparam stall_t STALL_IF   = 6'b000011;
   localparam stall_t STALL_NONE = 6'b000000;

   typedef enum logic [1:0] {
      PCTRL_RUN     = 2'b01,
      PCTRL_WAIT_IF = 2'b10
   } pctrl_state_e;

   function automatic stall_t stall_vec(input logic req_mem, input logic req_ex,
                                        input logic req_id, input logic req_if);
      if (req_mem)     return STALL_MEM;
      else if (req_ex) return STALL_EX;
      else if (req_id) return STALL_ID;
      else if (req_if) return STALL_IF;
      else             return STALL_NONE;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive PC-stall cycles into a sticky timeout, plus a saturating debug count.
// Latency: timeout rises the cycle after the STALL_LIMIT-th consecutive stall; no backpressure.
module stall_watchdog
   import pipeline_ctrl_pkg::*;
#(
   parameter int STALL_LIMIT = 1024,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_pc,
   input  logic             flush,
   output logic             stall_timeout_o,
   output logic [CNT_W-1:0] stall_cycles_o
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STALL_LIMIT - 1);

   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
   logic             timeout_q, timeout_d;

   always_comb begin
      run_cnt_d = run_cnt_q;
      cyc_cnt_d = cyc_cnt_q;
      timeout_d = timeout_q;

      if (stall_pc != STOP || flush) begin
         run_cnt_d = '0;
      end else begin
         if (run_cnt_q != CNT_MAX) run_cnt_d = run_cnt_q + CNT_ONE;
         // this stalled cycle is the STALL_LIMIT-th in a row
         if (run_cnt_q >= LIMIT_M1) timeout_d = 1'b1;
      end

      if (stall_pc == STOP && cyc_cnt_q != CNT_MAX) cyc_cnt_d = cyc_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt_q <= '0;
         cyc_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         run_cnt_q <= run_cnt_d;
         cyc_cnt_q <= cyc_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign stall_timeout_o = timeout_q;
   assign stall_cycles_o  = cyc_cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: merges stage stall requests, accepts MEM exceptions/ERET, flushes and redirects PC.
// Latency: zero-cycle stall/flush/redirect; redirect is deferred while a fetch is outstanding (if_busy).
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
   parameter int          STALL_LIMIT = 1024,
   parameter int          CNT_W       = 16
) (
   input  logic                      cpu_clk_75M,
   input  logic                      cpu_rst,
   input  logic                      stallreq_if,
   input  logic                      stallreq_id,
   input  logic                      stallreq_ex,
   input  logic                      stallreq_mem,
   input  logic                      if_busy,
   input  logic [EXC_CODE_WIDTH-1:0] exc_code_i,
   input  logic [31:0]               cp0_epc_i,
   output logic [STALL_W-1:0]        stall,
   output logic                      flush,
   output logic                      pc_redirect,
   output logic [31:0]               redirect_pc,
   output logic                      stall_timeout_o,
   output logic [CNT_W-1:0]          stall_cycles_o
);

   pctrl_state_e state_q, state_d;
   logic [31:0]  pend_pc_q, pend_pc_d;
   logic [31:0]  exc_target;

   always_comb begin
      exc_target  = (exc_code_i == EC_ERET) ? cp0_epc_i : EXC_VECTOR;
      state_d     = state_q;
      pend_pc_d   = pend_pc_q;
      stall       = STALL_NONE;
      flush       = 1'b0;
      pc_redirect = 1'b0;
      redirect_pc = 32'h0;

      case (state_q)
         PCTRL_RUN: begin
            stall = stall_vec(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
            // MEM must be idle on the data bus before its exception can be taken
            if (exc_code_i != EC_NONE && !stallreq_mem) begin
               stall = STALL_NONE;
               flush = 1'b1;
               if (if_busy) begin
                  pend_pc_d = exc_target;
                  state_d   = PCTRL_WAIT_IF;
               end else begin
                  pc_redirect = 1'b1;
                  redirect_pc = exc_target;
               end
            end
         end
         PCTRL_WAIT_IF: begin
            stall = STALL_IF;
            if (!if_busy) begin
               // second flush drops whatever the stale fetch delivered
               stall       = STALL_NONE;
               flush       = 1'b1;
               pc_redirect = 1'b1;
               redirect_pc = pend_pc_q;
               state_d     = PCTRL_RUN;
            end
         end
         default: state_d = PCTRL_RUN;
      endcase

      if (cpu_rst) begin
         stall       = STALL_NONE;
         flush       = 1'b0;
         pc_redirect = 1'b0;
         redirect_pc = 32'h0;
      end
   end

   always_ff @(posedge cpu_clk_75M) begin
      if (cpu_rst) begin
         state_q   <= PCTRL_RUN;
         pend_pc_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   stall_watchdog #(
      .STALL_LIMIT (STALL_LIMIT),
      .CNT_W       (CNT_W)
   ) u_stall_watchdog (
      .clk             (cpu_clk_75M),
      .rst             (cpu_rst),
      .stall_pc        (stall[0]),
      .flush           (flush),
      .stall_timeout_o (stall_timeout_o),
      .stall_cycles_o  (stall_cycles_o)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a cycle-level reference model and hand-computed literal checks.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int          LIMIT = 8;
   localparam int          CW    = 6;
   localparam logic [31:0] EVEC  = 32'hBFC0_0380;
   localparam logic [31:0] EPC   = 32'h8000_1234;

   logic                      cpu_clk_75M = 1'b0;
   logic                      cpu_rst;
   logic                      stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, if_busy;
   logic [EXC_CODE_WIDTH-1:0] exc_code_i;
   logic [31:0]               cp0_epc_i;
   logic [STALL_W-1:0]        stall;
   logic                      flush, pc_redirect, stall_timeout_o;
   logic [31:0]               redirect_pc;
   logic [CW-1:0]             stall_cycles_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   pipeline_ctrl #(.EXC_VECTOR(EVEC), .STALL_LIMIT(LIMIT), .CNT_W(CW)) dut (
      .cpu_clk_75M     (cpu_clk_75M),
      .cpu_rst         (cpu_rst),
      .stallreq_if     (stallreq_if),
      .stallreq_id     (stallreq_id),
      .stallreq_ex     (stallreq_ex),
      .stallreq_mem    (stallreq_mem),
      .if_busy         (if_busy),
      .exc_code_i      (exc_code_i),
      .cp0_epc_i       (cp0_epc_i),
      .stall           (stall),
      .flush           (flush),
      .pc_redirect     (pc_redirect),
      .redirect_pc     (redirect_pc),
      .stall_timeout_o (stall_timeout_o),
      .stall_cycles_o  (stall_cycles_o)
   );

   always #5 cpu_clk_75M = ~cpu_clk_75M;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pipeline mode, pending target, unbounded stall streak and total
   bit          m_wait    = 1'b0;
   logic [31:0] m_pend    = 32'h0;
   int          m_streak  = 0;
   int          m_stalled = 0;
   bit          m_tmo     = 1'b0;

   always @(negedge cpu_clk_75M) begin
      logic [5:0]  e_stall;
      logic        e_flush, e_red;
      logic [31:0] e_pc, tgt;
      int          depth, e_cyc;
      e_stall = 6'h0; e_flush = 1'b0; e_red = 1'b0; e_pc = 32'h0;
      tgt = (exc_code_i == EC_ERET) ? cp0_epc_i : EVEC;
      depth = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
      if (!cpu_rst) begin
         if (m_wait) begin
            if (if_busy) e_stall = 6'b000011;
            else begin e_flush = 1'b1; e_red = 1'b1; e_pc = m_pend; end
         end else if (exc_code_i != EC_NONE && !stallreq_mem) begin
            e_flush = 1'b1;
            if (!if_busy) begin e_red = 1'b1; e_pc = tgt; end
         end else begin
            e_stall = 6'((1 << depth) - 1);
         end
      end
      e_cyc = (m_stalled > (1 << CW) - 1) ? (1 << CW) - 1 : m_stalled;
      if (chk_en) begin
         chk("model_stall",   32'(stall),           32'(e_stall));
         chk("model_flush",   32'(flush),           32'(e_flush));
         chk("model_redir",   32'(pc_redirect),     32'(e_red));
         chk("model_rpc",     redirect_pc,          e_pc);
         chk("model_timeout", 32'(stall_timeout_o), 32'(m_tmo));
         chk("model_cycles",  32'(stall_cycles_o),  32'(e_cyc));
      end
      if (cpu_rst) begin
         m_wait = 1'b0; m_pend = 32'h0; m_streak = 0; m_stalled = 0; m_tmo = 1'b0;
      end else begin
         if (e_stall[0] && !e_flush) begin
            m_streak++;
            if (m_streak >= LIMIT) m_tmo = 1'b1;
         end else m_streak = 0;
         if (e_stall[0]) m_stalled++;
         if (m_wait && !if_busy) m_wait = 1'b0;
         else if (!m_wait && e_flush && if_busy) begin m_wait = 1'b1; m_pend = tgt; end
      end
   end

   task automatic apply(input logic m, input logic x, input logic d, input logic f, input logic b,
                        input logic [EXC_CODE_WIDTH-1:0] ec, input logic [31:0] epc);
      stallreq_mem = m; stallreq_ex = x; stallreq_id = d; stallreq_if = f;
      if_busy = b; exc_code_i = ec; cp0_epc_i = epc;
      @(negedge cpu_clk_75M);
   endtask

   task automatic adv;
      @(posedge cpu_clk_75M);
      #1;
   endtask

   task automatic idle;
      apply(0, 0, 0, 0, 0, EC_NONE, 32'h0);
   endtask

   initial begin
      cpu_rst = 1'b1;
      stallreq_mem = 0; stallreq_ex = 0; stallreq_id = 0; stallreq_if = 0;
      if_busy = 0; exc_code_i = EC_NONE; cp0_epc_i = 32'h0;
      adv();
      chk_en = 1'b1;
      cpu_rst = 1'b0;

      idle();
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_redir", 32'(pc_redirect), 32'h0);
      chk("rst_rpc", redirect_pc, 32'h0);
      chk("rst_tmo", 32'(stall_timeout_o), 32'h0);
      chk("rst_cyc", 32'(stall_cycles_o), 32'h0);
      adv();

      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 1, 0, 0, EC_NONE, 32'h0);
         chk("id_stall", 32'(stall), 32'h07);
         chk("id_flush", 32'(flush), 32'h0);
         adv();
      end
      idle();
      chk("id_cycles", 32'(stall_cycles_o), 32'd3);
      adv();

      apply(1, 1, 0, 1, 0, EC_NONE, 32'h0);
      chk("prio_stall", 32'(stall), 32'h1F);
      adv();

      apply(0, 0, 0, 0, 0, EC_OV, 32'h0);
      chk("exc_flush", 32'(flush), 32'h1);
      chk("exc_redir", 32'(pc_redirect), 32'h1);
      chk("exc_rpc", redirect_pc, 32'hBFC0_0380);
      chk("exc_stall", 32'(stall), 32'h0);
      adv();
      idle();
      chk("post_exc_flush", 32'(flush), 32'h0);
      chk("post_exc_redir", 32'(pc_redirect), 32'h0);
      chk("post_exc_rpc", redirect_pc, 32'h0);
      adv();

      apply(0, 0, 0, 0, 1, EC_ERET, EPC);
      chk("eret_flush", 32'(flush), 32'h1);
      chk("eret_noredir", 32'(pc_redirect), 32'h0);
      adv();
      for (int i = 0; i < 3; i++) begin
         apply(1, 0, 0, 0, 1, EC_ERET, EPC);
         chk("wait_stall", 32'(stall), 32'h03);
         chk("wait_flush", 32'(flush), 32'h0);
         adv();
      end
      apply(0, 0, 0, 0, 0, EC_NONE, 32'h0);
      chk("wait_end_flush", 32'(flush), 32'h1);
      chk("wait_end_redir", 32'(pc_redirect), 32'h1);
      chk("wait_end_rpc", redirect_pc, 32'h8000_1234);
      adv();
      for (int i = 0; i < 2; i++) begin
         apply(1, 0, 0, 0, 0, EC_OV, 32'h0);
         chk("held_stall", 32'(stall), 32'h1F);
         chk("held_flush", 32'(flush), 32'h0);
         adv();
      end
      apply(0, 0, 0, 0, 0, EC_OV, 32'h0);
      chk("held_take", 32'(flush), 32'h1);
      chk("held_rpc", redirect_pc, 32'hBFC0_0380);
      adv();

      cpu_rst = 1'b1; idle(); adv(); cpu_rst = 1'b0;
      for (int i = 0; i < LIMIT; i++) begin
         apply(0, 1, 0, 0, 0, EC_NONE, 32'h0);
         if (i == LIMIT - 1) chk("wd_before", 32'(stall_timeout_o), 32'h0);
         adv();
      end
      idle();
      chk("wd_set", 32'(stall_timeout_o), 32'h1);
      chk("wd_cycles", 32'(stall_cycles_o), 32'd8);
      adv();
      idle();
      chk("wd_sticky", 32'(stall_timeout_o), 32'h1);
      adv();

      for (int i = 0; i < 70; i++) begin
         apply(0, 0, 0, 1, 0, EC_NONE, 32'h0);
         adv();
      end
      idle();
      chk("cyc_saturate", 32'(stall_cycles_o), 32'd63);
      adv();

      cpu_rst = 1'b1; idle(); adv(); cpu_rst = 1'b0;
      idle();
      chk("rst_clr_tmo", 32'(stall_timeout_o), 32'h0);
      chk("rst_clr_cyc", 32'(stall_cycles_o), 32'h0);
      adv();
      apply(0, 0, 0, 0, 1, EC_ERET, EPC);
      adv();
      apply(0, 0, 0, 0, 1, EC_NONE, 32'h0);
      chk("r6_wait_stall", 32'(stall), 32'h03);
      adv();
      cpu_rst = 1'b1;
      apply(0, 0, 0, 0, 1, EC_NONE, 32'h0);
      adv();
      cpu_rst = 1'b0;
      apply(0, 0, 0, 0, 0, EC_NONE, 32'h0);
      chk("r6_noredir", 32'(pc_redirect), 32'h0);
      chk("r6_noflush", 32'(flush), 32'h0);
      chk("r6_stall", 32'(stall), 32'h0);
      chk("r6_rpc", redirect_pc, 32'h0);
      adv();
      idle();
      adv();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
